serial_add: RTL and testbench

SERIAL_ADD -- requirements
Module: serial_add

---
 rtl/serial_add.sv | 157 +++++++++++++++
 tb/tb_serial_add.sv | 177 +++++++++++++++++
 2 files changed

// File: rtl/serial_add.sv
// Purpose     : bit-serial adder, one full-adder cell, LSB first; sum/carry/signed overflow.
// Latency     : start sampled at edge k -> done high for the cycle after edge k+WIDTH.
// Backpressure: none; start is accepted only in IDLE or DONE and is ignored while busy.
module serial_add #(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             carry_in,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] sum,
   output logic             carry,
   output logic             overflow
);

   localparam int CW = $clog2(WIDTH) + 1;
   localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t           state_q, state_d;

   // operand shift registers, running carry and bit counter
   logic [WIDTH-1:0] a_q, a_d;
   logic [WIDTH-1:0] b_q, b_d;
   logic             c_q, c_d;
   logic [CW-1:0]    cnt_q, cnt_d;

   // result registers; sum fills from the MSB side as bits are produced
   logic [WIDTH-1:0] sum_q, sum_d;
   logic             carry_q, carry_d;
   logic             ovf_q, ovf_d;

   logic             accept;
   logic             last_bit;
   logic             fa_sum;
   logic             fa_cout;

   // The single full-adder cell working on the current LSBs and the running carry
   always_comb begin
      fa_sum  = a_q[0] ^ b_q[0] ^ c_q;
      fa_cout = (a_q[0] & b_q[0]) | (a_q[0] & c_q) | (b_q[0] & c_q);
   end

   // Start qualification and final-bit detection
   always_comb begin
      accept   = start && (state_q != RUN);
      last_bit = (state_q == RUN) && (cnt_q == LAST_BIT);
   end

   // FSM state register
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // FSM next-state logic
   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE: begin
            if (start) begin
               state_d = RUN;
            end
         end
         RUN: begin
            if (last_bit) begin
               state_d = DONE;
            end
         end
         DONE: begin
            // a start here chains straight into the next addition
            if (start) begin
               state_d = RUN;
            end else begin
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // FSM outputs: busy while bits are being processed, done for the single DONE cycle
   always_comb begin
      busy = (state_q == RUN);
      done = (state_q == DONE);
   end

   // Datapath next-state: latch operands on accept, otherwise shift one bit per RUN cycle
   always_comb begin
      a_d     = a_q;
      b_d     = b_q;
      c_d     = c_q;
      cnt_d   = cnt_q;
      sum_d   = sum_q;
      carry_d = carry_q;
      ovf_d   = ovf_q;
      if (accept) begin
         // results are left alone so the previous answer stays visible until shifting starts
         a_d   = a;
         b_d   = b;
         c_d   = carry_in;
         cnt_d = '0;
      end else if (state_q == RUN) begin
         a_d   = {1'b0, a_q[WIDTH-1:1]};
         b_d   = {1'b0, b_q[WIDTH-1:1]};
         c_d   = fa_cout;
         sum_d = {fa_sum, sum_q[WIDTH-1:1]};
         cnt_d = cnt_q + CW'(1);
         if (last_bit) begin
            // c_q is the carry into the MSB here, fa_cout the carry out of it
            carry_d = fa_cout;
            ovf_d   = c_q ^ fa_cout;
         end
      end
   end

   // Datapath registers
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         a_q     <= '0;
         b_q     <= '0;
         c_q     <= 1'b0;
         cnt_q   <= '0;
         sum_q   <= '0;
         carry_q <= 1'b0;
         ovf_q   <= 1'b0;
      end else begin
         a_q     <= a_d;
         b_q     <= b_d;
         c_q     <= c_d;
         cnt_q   <= cnt_d;
         sum_q   <= sum_d;
         carry_q <= carry_d;
         ovf_q   <= ovf_d;
      end
   end

   // Result outputs come straight from registers
   always_comb begin
      sum      = sum_q;
      carry    = carry_q;
      overflow = ovf_q;
   end

endmodule

// File: tb/tb_serial_add.sv
// Directed bench for serial_add: an 8-bit instance for the latency/edge cases,
// and a 2-bit instance swept over every operand/carry combination.
module tb_serial_add;

   logic       clk = 1'b0;
   always #5 clk = ~clk;

   // 8-bit instance
   logic       rst8, start8, ci8, busy8, done8, carry8, ovf8;
   logic [7:0] a8, b8, sum8;

   // 2-bit instance
   logic       rst2, start2, ci2, busy2, done2, carry2, ovf2;
   logic [1:0] a2, b2, sum2;

   int checks = 0;
   int errors = 0;

   serial_add #(.WIDTH(8)) dut8 (
      .clk(clk), .rst(rst8), .start(start8), .a(a8), .b(b8), .carry_in(ci8),
      .busy(busy8), .done(done8), .sum(sum8), .carry(carry8), .overflow(ovf8)
   );

   serial_add #(.WIDTH(2)) dut2 (
      .clk(clk), .rst(rst2), .start(start2), .a(a2), .b(b2), .carry_in(ci2),
      .busy(busy2), .done(done2), .sum(sum2), .carry(carry2), .overflow(ovf2)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Called at a negedge. Launches one 8-bit add, then keeps driving junk operands
   // (with start held high if hold=1) until done shows up or the budget runs out.
   task automatic op8(input logic [7:0] ta, input logic [7:0] tb_, input logic tci, input logic hold,
                      input logic [7:0] es, input logic ec, input logic eo, input string tag);
      int  idx;
      int  busyc;
      bit  seen;
      start8 = 1'b1; a8 = ta; b8 = tb_; ci8 = tci;
      @(posedge clk); @(negedge clk);
      idx = 0; busyc = 0; seen = 0;
      while (!seen && idx < 20) begin
         if (done8) begin
            seen = 1;
         end else begin
            if (busy8) busyc++;
            start8 = hold; a8 = 8'h55; b8 = 8'h55; ci8 = 1'b1;
            @(posedge clk); @(negedge clk);
            idx++;
         end
      end
      start8 = 1'b0;
      chk({tag, " done_seen"}, 32'(seen), 32'd1);
      chk({tag, " latency"}, 32'(idx), 32'd8);
      chk({tag, " busy_cycles"}, 32'(busyc), 32'd8);
      chk({tag, " busy_at_done"}, 32'(busy8), 32'd0);
      chk({tag, " sum"}, 32'(sum8), 32'(es));
      chk({tag, " carry"}, 32'(carry8), 32'(ec));
      chk({tag, " overflow"}, 32'(ovf8), 32'(eo));
   endtask

   // One cycle after done with no new start: back to idle, result still held
   task automatic drop8(input logic [7:0] es, input string tag);
      @(posedge clk); @(negedge clk);
      chk({tag, " done_drop"}, 32'(done8), 32'd0);
      chk({tag, " idle_busy"}, 32'(busy8), 32'd0);
      chk({tag, " sum_hold"}, 32'(sum8), 32'(es));
   endtask

   task automatic op2(input logic [1:0] ta, input logic [1:0] tb_, input logic tci);
      int idx;
      bit seen;
      int total;
      int sa, sb, r;
      logic ov;
      start2 = 1'b1; a2 = ta; b2 = tb_; ci2 = tci;
      @(posedge clk); @(negedge clk);
      idx = 0; seen = 0;
      while (!seen && idx < 10) begin
         if (done2) begin
            seen = 1;
         end else begin
            start2 = 1'b0; a2 = ~ta; b2 = ~tb_; ci2 = ~tci;
            @(posedge clk); @(negedge clk);
            idx++;
         end
      end
      start2 = 1'b0;
      total = int'(ta) + int'(tb_) + int'(tci);
      sa = ta[1] ? int'(ta) - 4 : int'(ta);
      sb = tb_[1] ? int'(tb_) - 4 : int'(tb_);
      r  = sa + sb + int'(tci);
      ov = (r > 1) || (r < -2);
      chk($sformatf("w2 a=%0d b=%0d ci=%0d latency", ta, tb_, tci), 32'(idx), 32'd2);
      chk($sformatf("w2 a=%0d b=%0d ci=%0d carry_sum", ta, tb_, tci), 32'({carry2, sum2}), 32'(total));
      chk($sformatf("w2 a=%0d b=%0d ci=%0d overflow", ta, tb_, tci), 32'(ovf2), 32'(ov));
   endtask

   initial begin
      int dones;
      rst8 = 1'b0; rst2 = 1'b0;
      start8 = 1'b0; a8 = 8'h00; b8 = 8'h00; ci8 = 1'b0;
      start2 = 1'b0; a2 = 2'd0; b2 = 2'd0; ci2 = 1'b0;
      #2 rst8 = 1'b1; rst2 = 1'b1;
      #1;
      chk("reset busy", 32'(busy8), 32'd0);
      chk("reset done", 32'(done8), 32'd0);
      chk("reset sum", 32'(sum8), 32'd0);
      chk("reset carry", 32'(carry8), 32'd0);
      chk("reset overflow", 32'(ovf8), 32'd0);
      @(negedge clk);
      rst8 = 1'b0; rst2 = 1'b0;

      // first start after reset release is taken on the very next edge
      op8(8'h00, 8'h00, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, "zero");
      drop8(8'h00, "zero");
      op8(8'hFF, 8'h01, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0, "ff_plus_1");
      drop8(8'h00, "ff_plus_1");
      op8(8'h7F, 8'h01, 1'b0, 1'b0, 8'h80, 1'b0, 1'b1, "7f_plus_1");
      drop8(8'h80, "7f_plus_1");
      op8(8'h80, 8'h80, 1'b1, 1'b0, 8'h01, 1'b1, 1'b1, "80_plus_80_ci");
      drop8(8'h01, "80_plus_80_ci");

      // reset in the 4th RUN cycle: previous carry/overflow were 1, partial sum nonzero
      start8 = 1'b1; a8 = 8'h33; b8 = 8'h11; ci8 = 1'b0;
      @(posedge clk); @(negedge clk);
      start8 = 1'b0;
      repeat (3) begin
         @(posedge clk); @(negedge clk);
      end
      chk("abort busy_before", 32'(busy8), 32'd1);
      rst8 = 1'b1;
      #1;
      chk("abort busy", 32'(busy8), 32'd0);
      chk("abort done", 32'(done8), 32'd0);
      chk("abort sum", 32'(sum8), 32'd0);
      chk("abort carry", 32'(carry8), 32'd0);
      chk("abort overflow", 32'(ovf8), 32'd0);
      @(negedge clk);
      rst8 = 1'b0;
      dones = 0;
      repeat (12) begin
         @(posedge clk); @(negedge clk);
         if (done8) dones++;
      end
      chk("abort no_done", 32'(dones), 32'd0);
      op8(8'h33, 8'h11, 1'b0, 1'b0, 8'h44, 1'b0, 1'b0, "after_abort");
      drop8(8'h44, "after_abort");

      // start held high through RUN with different operands must be ignored
      op8(8'h0F, 8'h01, 1'b0, 1'b1, 8'h10, 1'b0, 1'b0, "midrun_start");
      drop8(8'h10, "midrun_start");

      // back-to-back: second start issued in the DONE cycle of the first
      op8(8'h3C, 8'h0A, 1'b0, 1'b0, 8'h46, 1'b0, 1'b0, "b2b_first");
      op8(8'h01, 8'h02, 1'b1, 1'b0, 8'h04, 1'b0, 1'b0, "b2b_second");
      drop8(8'h04, "b2b_second");

      // exhaustive 2-bit sweep
      for (int ia = 0; ia < 4; ia++) begin
         for (int ib = 0; ib < 4; ib++) begin
            for (int ic = 0; ic < 2; ic++) begin
               op2(2'(ia), 2'(ib), 1'(ic));
            end
         end
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
